// File: rtl/dual_mode_buffer.sv
// ---------------------------------------------------------------------------
// dual_mode_buffer
//
// Circular buffer of DEPTH entries that serves pops either oldest-first
// (FIFO, mode 00) or newest-first (LIFO, mode 01). Modes 10/11 freeze the
// buffer. Pop data is registered: it appears on dout one cycle after the
// POP edge, marked by a single-cycle dout_valid pulse. Status flags are
// registered from the post-edge occupancy.
//
// Optional feature: define DUAL_MODE_BUFFER_ERR_FLAGS_EN to add the sticky
// overflow (rejected PUSH) and underflow (rejected POP) outputs.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   din          : push data
//   mode         : 00 FIFO, 01 LIFO, 10/11 hold
//   opcode       : 00 idle, 01 PUSH, 10 POP, 11 PUSH_POP
//   dout         : registered pop data, holds last value
//   dout_valid   : one-cycle pulse when dout was updated
//   full / empty : count == DEPTH / count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   overflow     : sticky, rejected PUSH seen (macro only)
//   underflow    : sticky, rejected POP seen (macro only)
//   count        : current occupancy
// ---------------------------------------------------------------------------
module dual_mode_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [1:0]                   mode,
    input  logic [1:0]                   opcode,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
`ifdef DUAL_MODE_BUFFER_ERR_FLAGS_EN
    output logic                         overflow,
    output logic                         underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    localparam logic [1:0] MODE_FIFO   = 2'b00;
    localparam logic [1:0] MODE_LIFO   = 2'b01;
    localparam logic [1:0] OP_PUSH     = 2'b01;
    localparam logic [1:0] OP_POP      = 2'b10;
    localparam logic [1:0] OP_PUSH_POP = 2'b11;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  do_write, do_pop, bypass;
    logic                  push_rej, pop_rej;

    // Explicit compare against DEPTH-1 so non-power-of-two depths wrap too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PTR_LAST : p - 1'b1;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        pop_data   = mem[rd_ptr];
        do_write   = 1'b0;
        do_pop     = 1'b0;
        bypass     = 1'b0;
        push_rej   = 1'b0;
        pop_rej    = 1'b0;

        if (mode == MODE_FIFO || mode == MODE_LIFO) begin
            case (opcode)
                OP_PUSH: begin
                    if (full) begin
                        push_rej = 1'b1;
                    end else begin
                        do_write   = 1'b1;
                        wr_ptr_nxt = ptr_inc(wr_ptr);
                        count_nxt  = count + 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        pop_rej = 1'b1;
                    end else begin
                        do_pop    = 1'b1;
                        count_nxt = count - 1'b1;
                        if (mode == MODE_LIFO) begin
                            // Newest entry sits just behind the write pointer.
                            pop_data   = mem[ptr_dec(wr_ptr)];
                            wr_ptr_nxt = ptr_dec(wr_ptr);
                        end else begin
                            rd_ptr_nxt = ptr_inc(rd_ptr);
                        end
                    end
                end
                OP_PUSH_POP: begin
                    if (mode == MODE_LIFO) begin
                        // Push-then-pop of the same word: forward din, touch nothing.
                        bypass = 1'b1;
                    end else begin
                        // Legal when full: the slot being read is the one overwritten,
                        // and the read sees the pre-edge contents.
                        do_write   = 1'b1;
                        wr_ptr_nxt = ptr_inc(wr_ptr);
                        if (empty) begin
                            count_nxt = count + 1'b1;
                        end else begin
                            do_pop     = 1'b1;
                            rd_ptr_nxt = ptr_inc(rd_ptr);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; stale words are unreachable because the
    // pointers and count are cleared, and leaving it unreset keeps it a
    // plain RAM.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LEVEL <= 0);
            almost_empty <= 1'b1;
            dout         <= '0;
            dout_valid   <= 1'b0;
`ifdef DUAL_MODE_BUFFER_ERR_FLAGS_EN
            overflow     <= 1'b0;
            underflow    <= 1'b0;
`endif
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == CNT_FULL);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_AF);
            almost_empty <= (count_nxt <= CNT_AE);
            dout_valid   <= do_pop | bypass;
            if (bypass) begin
                dout <= din;
            end else if (do_pop) begin
                dout <= pop_data;
            end
`ifdef DUAL_MODE_BUFFER_ERR_FLAGS_EN
            if (push_rej) overflow  <= 1'b1;
            if (pop_rej)  underflow <= 1'b1;
`endif
        end
    end

`ifndef DUAL_MODE_BUFFER_ERR_FLAGS_EN
    // Rejection strobes only feed the optional error flags.
    logic unused_rej;
    assign unused_rej = push_rej | pop_rej;
`endif

endmodule
